// File: rtl/booth_r4_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_r4_mult_seq
// Sequential radix-4 (modified Booth) multiplier with a per-operation
// signed/unsigned mode, a start/done handshake and a synchronous abort.
//
// Both operands are widened by two bits before use. Signed operands are
// sign-extended and unsigned operands are zero-extended. After widening, an
// unsigned operand is a non-negative signed number, so one signed Booth
// datapath covers both modes.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset (0 = reset)
//   start  in   operation request; sampled only while rdy=1
//   sgn    in   1 = operands are two's complement, 0 = unsigned; sampled with start
//   clr    in   synchronous abort; returns to IDLE without producing done
//   a      in   multiplicand [WIDTH-1:0]; sampled with start
//   b      in   multiplier   [WIDTH-1:0]; sampled with start
//   rdy    out  high in IDLE only
//   busy   out  high in RUN or DONE
//   done   out  single-cycle pulse; p holds the new product while it is high
//   p      out  product [2*WIDTH-1:0]; held until the next done
// -----------------------------------------------------------------------------
module booth_r4_mult_seq #(
    parameter int WIDTH = 8     // operand width; must be even and >= 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sgn,
    input  logic                 clr,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 rdy,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    // Each step consumes two multiplier bits, so the widened multiplier
    // needs W2/2 = WIDTH/2+1 steps.
    localparam int ITER = WIDTH / 2 + 1;
    localparam int W2   = WIDTH + 2;          // widened operand width
    localparam int PW   = W2 + 2;             // accumulator width; holds +/-2M without overflow
    localparam int CW   = $clog2(ITER);       // step counter width

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      acc_q,   acc_d;       // signed partial-product accumulator P
    logic [W2-1:0]      q_q,     q_d;         // multiplier shift register Q
    logic               q1_q,    q1_d;        // appended bit q_-1
    logic [W2-1:0]      m_q,     m_d;         // widened multiplicand M
    logic [CW-1:0]      cnt_q,   cnt_d;       // Booth step counter
    logic [2*WIDTH-1:0] p_q,     p_d;         // product output register

    // ------------------------------------------------------------------
    // Operand widening
    // ------------------------------------------------------------------
    logic [W2-1:0] a_ext;
    logic [W2-1:0] b_ext;

    always_comb begin
        a_ext = sgn ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
        b_ext = sgn ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    end

    // ------------------------------------------------------------------
    // One Booth step. The next accumulator, shift register and product
    // are formed here from the current registers.
    // ------------------------------------------------------------------
    logic [2:0]         sel;
    logic [PW-1:0]      m_pw;
    logic [PW-1:0]      m2_pw;
    logic [PW-1:0]      addend;
    logic               neg;
    logic [PW-1:0]      sum;
    logic [PW-1:0]      acc_step;
    logic [W2-1:0]      q_step;
    logic [2*WIDTH-1:0] prod_step;

    always_comb begin
        sel    = {q_q[1], q_q[0], q1_q};
        m_pw   = {{2{m_q[W2-1]}}, m_q};
        m2_pw  = {m_pw[PW-2:0], 1'b0};
        addend = '0;
        neg    = 1'b0;
        case (sel)
            3'b001, 3'b010: addend = m_pw;
            3'b011:         addend = m2_pw;
            3'b100: begin
                // -2M is computed as ~2M plus a carry-in of 1.
                addend = ~m2_pw;
                neg    = 1'b1;
            end
            3'b101, 3'b110: begin
                addend = ~m_pw;
                neg    = 1'b1;
            end
            default: begin
                // 000 and 111 select a zero digit.
                addend = '0;
                neg    = 1'b0;
            end
        endcase
        sum      = acc_q + addend + {{(PW-1){1'b0}}, neg};
        // Arithmetic shift right by two. The two bits shifted out of the
        // accumulator enter the top of Q.
        acc_step = {{2{sum[PW-1]}}, sum[PW-1:2]};
        q_step   = {sum[1:0], q_q[W2-1:2]};
        // The low 2*WIDTH bits of {P,Q} after the final step.
        prod_step = {acc_step[WIDTH-3:0], q_step};
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        case (state_q)
            S_IDLE: begin
                if (start && !clr) begin
                    m_d     = a_ext;
                    q_d     = b_ext;
                    q1_d    = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (clr) begin
                    // An abort discards the operation and leaves p unchanged.
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_step;
                    q_d   = q_step;
                    q1_d  = q_q[1];
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) begin
                        // Last step: capture the product on this edge so
                        // that p is valid while done is high.
                        p_d     = prod_step;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rdy  = (state_q == S_IDLE);
    assign busy = (state_q == S_RUN) || (state_q == S_DONE);
    assign done = (state_q == S_DONE);
    assign p    = p_q;

endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_r4_mult_seq
// Self-checking bench for booth_r4_mult_seq. It instantiates one 8-bit and
// one 16-bit multiplier. Expected products come from plain integer
// multiplication in a reference function. Expected latencies come from the
// handshake timing. Inputs are driven on the falling edge and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_booth_r4_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit instance
    logic        start8, sgn8, clr8;
    logic [7:0]  a8, b8;
    logic        rdy8, busy8, done8;
    logic [15:0] p8;

    // 16-bit instance
    logic        start16, sgn16, clr16;
    logic [15:0] a16, b16;
    logic        rdy16, busy16, done16;
    logic [31:0] p16;

    booth_r4_mult_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .clr(clr8),
        .a(a8), .b(b8), .rdy(rdy8), .busy(busy8), .done(done8), .p(p8)
    );

    booth_r4_mult_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .sgn(sgn16), .clr(clr16),
        .a(a16), .b(b16), .rdy(rdy16), .busy(busy16), .done(done16), .p(p16)
    );

    int checks = 0;
    int errors = 0;

    localparam int LAT8  = 6;   // ITER+1 cycles for WIDTH=8
    localparam int LAT16 = 10;  // ITER+1 cycles for WIDTH=16
    localparam int NRAND = 400; // random operations per mode per width

    // Reference model: exact integer product, truncated to 2*W bits.
    function automatic logic [15:0] ref8(input logic s, input logic [7:0] x, input logic [7:0] y);
        longint xv, yv;
        xv = s ? longint'($signed(x)) : longint'(x);
        yv = s ? longint'($signed(y)) : longint'(y);
        return 16'(xv * yv);
    endfunction

    function automatic logic [31:0] ref16(input logic s, input logic [15:0] x, input logic [15:0] y);
        longint xv, yv;
        xv = s ? longint'($signed(x)) : longint'(x);
        yv = s ? longint'($signed(y)) : longint'(y);
        return 32'(xv * yv);
    endfunction

    // Issue one 8-bit operation and wait for done. lat is the cycle number
    // in which done was seen, counting the start cycle as 0. lat is -1 on
    // timeout. The operands are scrambled after the start sample.
    task automatic op8(input logic s, input logic [7:0] x, input logic [7:0] y,
                       output logic [15:0] prod, output int lat);
        @(negedge clk);
        start8 = 1'b1; sgn8 = s; a8 = x; b8 = y;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
        lat  = -1;
        prod = p8;
        for (int c = 1; c <= 40; c++) begin
            if (done8) begin
                lat  = c;
                prod = p8;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic op16(input logic s, input logic [15:0] x, input logic [15:0] y,
                        output logic [31:0] prod, output int lat);
        @(negedge clk);
        start16 = 1'b1; sgn16 = s; a16 = x; b16 = y;
        @(negedge clk);
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = 1'($urandom);
        lat  = -1;
        prod = p16;
        for (int c = 1; c <= 60; c++) begin
            if (done16) begin
                lat  = c;
                prod = p16;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (rdy8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'h0) begin
            errors++;
            $display("FAIL reset8: rdy=%b busy=%b done=%b p=%h, expected 1 0 0 0000", rdy8, busy8, done8, p8);
        end
        checks++;
        if (rdy16 !== 1'b1 || busy16 !== 1'b0 || done16 !== 1'b0 || p16 !== 32'h0) begin
            errors++;
            $display("FAIL reset16: rdy=%b busy=%b done=%b p=%h, expected 1 0 0 0", rdy16, busy16, done16, p16);
        end
    endtask

    task automatic test_directed8;
        logic [7:0]  xs [5] = '{8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        logic [7:0]  ys [5] = '{8'h80, 8'hFF, 8'hFF, 8'h01, 8'h7F};
        logic        ss [5] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b1};
        logic [15:0] es [5] = '{16'h4000, 16'hFE01, 16'h0001, 16'hFFFF, 16'h0000};
        logic [15:0] pr;
        int lat;
        for (int i = 0; i < 5; i++) begin
            op8(ss[i], xs[i], ys[i], pr, lat);
            checks++;
            if (pr !== es[i] || lat != LAT8) begin
                errors++;
                $display("FAIL directed8[%0d]: p=%h lat=%0d, expected p=%h lat=%0d", i, pr, lat, es[i], LAT8);
            end else
                $display("directed8 sgn=%b %h*%h p=%h lat=%0d", ss[i], xs[i], ys[i], pr, lat);
        end
        @(negedge clk);
        checks++;
        if (rdy8 !== 1'b1 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL rdy_after_done: rdy=%b done=%b, expected 1 0", rdy8, done8);
        end
    endtask

    task automatic test_start_during_run;
        int ndone = 0;
        logic [15:0] pr = 16'h0;
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd3; b8 = 8'd5;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd7; b8 = 8'd9;   // during RUN: must be ignored
        @(negedge clk);
        start8 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done8) begin
                ndone++;
                pr = p8;
            end
            @(negedge clk);
        end
        checks++;
        if (ndone != 1 || pr !== 16'd15) begin
            errors++;
            $display("FAIL start_during_run: done_pulses=%0d p=%h, expected 1 000f", ndone, pr);
        end else
            $display("start_during_run done_pulses=%0d p=%h", ndone, pr);
    endtask

    task automatic test_back_to_back;
        logic [15:0] pr;
        int lat, t0, t1;
        op8(1'b1, 8'h12, 8'hF3, pr, lat);
        t0 = cyc;
        op8(1'b0, 8'hA5, 8'h5A, pr, lat);
        t1 = cyc;
        checks++;
        if (pr !== ref8(1'b0, 8'hA5, 8'h5A) || (t1 - t0) != LAT8 + 1) begin
            errors++;
            $display("FAIL back_to_back: p=%h spacing=%0d, expected p=%h spacing=%0d",
                     pr, t1 - t0, ref8(1'b0, 8'hA5, 8'h5A), LAT8 + 1);
        end else
            $display("back_to_back p=%h spacing=%0d", pr, t1 - t0);
        // The current cycle is the DONE cycle. A start here must be ignored.
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        @(negedge clk);
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b0 || rdy8 !== 1'b1) begin
            errors++;
            $display("FAIL start_on_done: busy=%b rdy=%b, expected 0 1", busy8, rdy8);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b1; a8 = 8'h33; b8 = 8'h44;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (rdy8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b busy=%b done=%b p=%h, expected 1 0 0 0000", rdy8, busy8, done8, p8);
        end else
            $display("reset_mid rdy=%b p=%h", rdy8, p8);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_clr;
        logic [15:0] pr;
        int lat, ndone = 0;
        op8(1'b0, 8'd3, 8'd5, pr, lat);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd7; b8 = 8'd9;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        checks++;
        if (rdy8 !== 1'b1 || p8 !== 16'd15) begin
            errors++;
            $display("FAIL clr_abort: rdy=%b p=%h, expected 1 000f", rdy8, p8);
        end
        for (int c = 0; c < 10; c++) begin
            if (done8) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone != 0 || p8 !== 16'd15) begin
            errors++;
            $display("FAIL clr_no_done: done_pulses=%0d p=%h, expected 0 000f", ndone, p8);
        end else
            $display("clr abort p=%h done_pulses=%0d", p8, ndone);
    endtask

    task automatic test_directed16;
        logic [31:0] pr;
        int lat;
        op16(1'b1, 16'h8000, 16'h7FFF, pr, lat);
        checks++;
        if (pr !== 32'hC0008000 || lat != LAT16) begin
            errors++;
            $display("FAIL directed16_s: p=%h lat=%0d, expected C0008000 %0d", pr, lat, LAT16);
        end else
            $display("directed16 8000*7fff p=%h lat=%0d", pr, lat);
        op16(1'b0, 16'hFFFF, 16'hFFFF, pr, lat);
        checks++;
        if (pr !== 32'hFFFE0001 || lat != LAT16) begin
            errors++;
            $display("FAIL directed16_u: p=%h lat=%0d, expected FFFE0001 %0d", pr, lat, LAT16);
        end else
            $display("directed16 ffff*ffff p=%h lat=%0d", pr, lat);
    endtask

    task automatic test_random;
        logic [15:0] pr8, e8;
        logic [31:0] pr16, e16;
        logic [7:0]  x8, y8;
        logic [15:0] x16, y16;
        logic        s;
        int lat, bad = 0;
        for (int m = 0; m < 2; m++) begin
            s = 1'(m);
            for (int i = 0; i < NRAND; i++) begin
                x8 = 8'($urandom); y8 = 8'($urandom);
                e8 = ref8(s, x8, y8);
                op8(s, x8, y8, pr8, lat);
                checks++;
                if (pr8 !== e8 || lat != LAT8) begin
                    errors++; bad++;
                    $display("FAIL random8 sgn=%b %h*%h: p=%h lat=%0d, expected %h %0d", s, x8, y8, pr8, lat, e8, LAT8);
                end
                x16 = 16'($urandom); y16 = 16'($urandom);
                e16 = ref16(s, x16, y16);
                op16(s, x16, y16, pr16, lat);
                checks++;
                if (pr16 !== e16 || lat != LAT16) begin
                    errors++; bad++;
                    $display("FAIL random16 sgn=%b %h*%h: p=%h lat=%0d, expected %h %0d", s, x16, y16, pr16, lat, e16, LAT16);
                end
            end
            $display("random sgn=%b ops=%0d bad=%0d", s, 2 * NRAND, bad);
        end
    endtask

    initial begin
        rst = 1'b0;
        start8 = 1'b0; sgn8 = 1'b0; clr8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; sgn16 = 1'b0; clr16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        test_reset;
        rst = 1'b1;
        test_directed8;
        test_start_during_run;
        test_back_to_back;
        test_reset_mid;
        test_clr;
        test_directed16;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
